fetch_ctrl: RTL and testbench

Instruction-fetch sequencer in the IFU, sitting between the program counter, the instruction memory port and the decode stage. It issues one instruction-memory request at a time at the current PC and buffers the returned instruction for decode. It drives the PC's `stall`, `compressed`, `je` and `ja` inputs so the PC advances only when decode consumes an instruction or when a redirect arrives. Redirects that land while a request is outstanding cause the stale response to be discarded.

---
 rtl/pipeline.sv | 12 +
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline.sv
// +----------------------------------------------------------------------+
// | Module      : pipeline (package)                                     |
// | Description : Core-wide pipeline constants shared by the IFU blocks. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline;
    localparam int XLEN = 32;
endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// +----------------------------------------------------------------------+
// | Module      : fetch_ctrl_if                                          |
// | Description : Instruction-memory and decode handshakes of the IFU.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_ctrl_if;
    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [pipeline::XLEN-1:0]  imem_addr;
    logic                       imem_rsp_valid;
    logic [31:0]                imem_rsp_data;

    logic                       inst_valid;
    logic                       inst_ready;
    logic [31:0]                inst;
    logic [pipeline::XLEN-1:0]  inst_pc;
    logic                       inst_compressed;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc, inst_compressed,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc, inst_compressed,
        output inst_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : fetch_ctrl                                             |
// | Description : Single-outstanding instruction-fetch sequencer.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_ctrl (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic [pipeline::XLEN-1:0]  curr_pc,
    output logic                            stall,
    output logic                            compressed,
    output logic                            je,
    output logic [pipeline::XLEN-1:0]       ja,
    input  wire logic                       redirect,
    input  wire logic [pipeline::XLEN-1:0]  redirect_addr,
    fetch_ctrl_if.master                    bus
);
    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                     r_state;
    logic                       r_kill;
    logic [pipeline::XLEN-1:0]  r_req_addr;
    logic [31:0]                r_inst;
    logic [pipeline::XLEN-1:0]  r_inst_pc;
    logic                       r_inst_comp;

    logic                       w_redirect;
    logic                       w_handoff;

    // Redirects are ignored while reset is asserted so the PC stays held.
    assign w_redirect = redirect & reset_n;
    assign w_handoff  = (r_state == S_HOLD) && bus.inst_ready && !w_redirect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_START;
            r_kill      <= 1'b0;
            r_req_addr  <= '0;
            r_inst      <= '0;
            r_inst_pc   <= '0;
            r_inst_comp <= 1'b0;
        end else begin
            case (r_state)
                S_START: r_state <= S_REQ;
                S_REQ: begin
                    // A killed request keeps its original address until accepted.
                    if (!r_kill)
                        r_req_addr <= curr_pc;
                    if (bus.imem_req_ready) begin
                        r_kill  <= 1'b0;
                        r_state <= (r_kill || redirect) ? S_DRAIN : S_WAIT;
                    end else if (redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (redirect) begin
                            r_state <= S_REQ;
                        end else begin
                            r_inst      <= bus.imem_rsp_data;
                            r_inst_pc   <= r_req_addr;
                            r_inst_comp <= (bus.imem_rsp_data[1:0] != 2'b11);
                            r_state     <= S_HOLD;
                        end
                    end else if (redirect) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_inst      <= '0;
                        r_inst_pc   <= '0;
                        r_inst_comp <= 1'b0;
                        r_state     <= S_REQ;
                    end else if (bus.inst_ready) begin
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rsp_valid)
                        r_state <= S_REQ;
                end
                default: r_state <= S_START;
            endcase
        end
    end

    assign bus.imem_req_valid  = (r_state == S_REQ);
    assign bus.imem_addr       = r_kill ? r_req_addr : curr_pc;
    assign bus.inst_valid      = (r_state == S_HOLD) && !w_redirect;
    assign bus.inst            = r_inst;
    assign bus.inst_pc         = r_inst_pc;
    assign bus.inst_compressed = r_inst_comp;

    assign je         = w_redirect;
    assign ja         = redirect_addr;
    assign stall      = !(w_redirect || w_handoff);
    assign compressed = r_inst_comp;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_ctrl                                          |
// | Description : Cycle-table directed bench for fetch_ctrl.             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_ctrl;
    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        rdr;
        logic [31:0] raddr;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_comp;
        logic        e_stall;
        logic        e_je;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] curr_pc;
    logic        stall;
    logic        compressed;
    logic        je;
    logic [31:0] ja;
    logic        redirect;
    logic [31:0] redirect_addr;

    int checks;
    int failures;

    vec_t tbl[$];

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .curr_pc       (curr_pc),
        .stall         (stall),
        .compressed    (compressed),
        .je            (je),
        .ja            (ja),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .bus           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic [31:0] pc, input logic rdr, input logic [31:0] raddr,
        input logic rdy, input logic rv, input logic [31:0] rdata, input logic ir,
        input logic e_rv, input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_inst,
        input logic [31:0] e_ipc, input logic e_comp, input logic e_stall, input logic e_je);
        vec_t v;
        v.rst = rst; v.pc = pc; v.rdr = rdr; v.raddr = raddr;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
        v.e_ipc = e_ipc; v.e_comp = e_comp; v.e_stall = e_stall; v.e_je = e_je;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    // Inputs are driven on the falling edge and outputs checked 1ns later.
    task automatic run_row(input vec_t v, input int idx);
        reset_n                 = !v.rst;
        curr_pc                 = v.pc;
        redirect                = v.rdr;
        redirect_addr           = v.raddr;
        bus.imem_req_ready      = v.rdy;
        bus.imem_rsp_valid      = v.rv;
        bus.imem_rsp_data       = v.rdata;
        bus.inst_ready          = v.ir;
        #1;
        chk("imem_req_valid",  idx, {31'd0, bus.imem_req_valid},  {31'd0, v.e_rv});
        chk("imem_addr",       idx, bus.imem_addr,                v.e_addr);
        chk("inst_valid",      idx, {31'd0, bus.inst_valid},      {31'd0, v.e_iv});
        chk("inst",            idx, bus.inst,                     v.e_inst);
        chk("inst_pc",         idx, bus.inst_pc,                  v.e_ipc);
        chk("inst_compressed", idx, {31'd0, bus.inst_compressed}, {31'd0, v.e_comp});
        chk("compressed",      idx, {31'd0, compressed},          {31'd0, v.e_comp});
        chk("stall",           idx, {31'd0, stall},               {31'd0, v.e_stall});
        chk("je",              idx, {31'd0, je},                  {31'd0, v.e_je});
        if (v.e_je)
            chk("ja", idx, ja, v.raddr);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        reset_n            = 1'b0;
        curr_pc            = '0;
        redirect           = 1'b0;
        redirect_addr      = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Sequential fetch, compressed fetch, decode backpressure, redirect in WAIT.
        tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 0,            0, 0, 32'h0,   0, 32'h0,          32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,   0, 0, 1, 0, 0,            0, 1, 32'h0,   0, 32'h0,          32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,   0, 0, 0, 1, 32'h00000013, 0, 0, 32'h0,   0, 32'h0,          32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 0,            1, 0, 32'h0,   1, 32'h00000013,   32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h4,   0, 0, 1, 0, 0,            0, 1, 32'h4,   0, 32'h00000013,   32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 32'h4,   0, 0, 0, 1, 32'h00004501, 0, 0, 32'h4,   0, 32'h00000013,   32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 32'h4,   0, 0, 0, 0, 0,            1, 0, 32'h4,   1, 32'h00004501,   32'h4, 1, 0, 0));
        tbl.push_back(mk(0, 32'h6,   0, 0, 1, 0, 0,            0, 1, 32'h6,   0, 32'h00004501,   32'h4, 1, 1, 0));
        tbl.push_back(mk(0, 32'h6,   0, 0, 0, 1, 32'h00a00093, 0, 0, 32'h6,   0, 32'h00004501,   32'h4, 1, 1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 32'h6, 0, 0, 0, 0, 0,          0, 0, 32'h6,   1, 32'h00a00093,   32'h6, 0, 1, 0));
        tbl.push_back(mk(0, 32'h6,   0, 0, 0, 0, 0,            1, 0, 32'h6,   1, 32'h00a00093,   32'h6, 0, 0, 0));
        tbl.push_back(mk(0, 32'ha,   0, 0, 1, 0, 0,            0, 1, 32'ha,   0, 32'h00a00093,   32'h6, 0, 1, 0));
        tbl.push_back(mk(0, 32'ha,   1, 32'h100, 0, 0, 0,      0, 0, 32'ha,   0, 32'h00a00093,   32'h6, 0, 0, 1));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 1, 32'hdeadbeef, 0, 0, 32'h100, 0, 32'h00a00093,   32'h6, 0, 1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 1, 0, 0,            0, 1, 32'h100, 0, 32'h00a00093,   32'h6, 0, 1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 1, 32'h00100113, 0, 0, 32'h100, 0, 32'h00a00093,   32'h6, 0, 1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0,            1, 0, 32'h100, 1, 32'h00100113, 32'h100, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++)
            run_row(tbl[i], i);

        // Redirect in REQ while memory stalls for three cycles.
        run_row(mk(0, 32'h104, 1, 32'h200, 0, 0, 0,     0, 1, 32'h104, 0, 32'h00100113, 32'h100, 0, 0, 1), 100);
        run_row(mk(0, 32'h200, 0, 0,       0, 0, 0,     0, 1, 32'h104, 0, 32'h00100113, 32'h100, 0, 1, 0), 101);
        run_row(mk(0, 32'h200, 0, 0,       0, 0, 0,     0, 1, 32'h104, 0, 32'h00100113, 32'h100, 0, 1, 0), 102);
        run_row(mk(0, 32'h200, 0, 0,       1, 0, 0,     0, 1, 32'h104, 0, 32'h00100113, 32'h100, 0, 1, 0), 103);
        run_row(mk(0, 32'h200, 0, 0,       0, 1, 32'hbad, 0, 0, 32'h200, 0, 32'h00100113, 32'h100, 0, 1, 0), 104);
        run_row(mk(0, 32'h200, 0, 0,       1, 0, 0,     0, 1, 32'h200, 0, 32'h00100113, 32'h100, 0, 1, 0), 105);
        run_row(mk(0, 32'h200, 0, 0,       0, 1, 32'h13, 0, 0, 32'h200, 0, 32'h00100113, 32'h100, 0, 1, 0), 106);

        // Redirect coincident with inst_ready in HOLD, then with a response in WAIT.
        run_row(mk(0, 32'h200, 1, 32'h300, 0, 0, 0,       1, 0, 32'h200, 0, 32'h13,   32'h200, 0, 0, 1), 200);
        run_row(mk(0, 32'h300, 0, 0,       1, 0, 0,       0, 1, 32'h300, 0, 32'h0,    32'h0,   0, 1, 0), 201);
        run_row(mk(0, 32'h300, 1, 32'h400, 0, 1, 32'h13,  0, 0, 32'h300, 0, 32'h0,    32'h0,   0, 0, 1), 202);
        run_row(mk(0, 32'h400, 0, 0,       1, 0, 0,       0, 1, 32'h400, 0, 32'h0,    32'h0,   0, 1, 0), 203);
        run_row(mk(0, 32'h400, 0, 0,       0, 1, 32'h4501, 0, 0, 32'h400, 0, 32'h0,   32'h0,   0, 1, 0), 204);
        run_row(mk(0, 32'h400, 0, 0,       0, 0, 0,       0, 0, 32'h400, 1, 32'h4501, 32'h400, 1, 1, 0), 205);

        // Asynchronous reset while holding an instruction, with hostile inputs.
        run_row(mk(1, 32'h400, 1, 32'h500, 1, 1, 32'h13,  1, 0, 32'h400, 0, 32'h0,    32'h0,   0, 1, 0), 300);
        run_row(mk(0, 32'h0,   0, 0,       0, 0, 0,       0, 0, 32'h0,   0, 32'h0,    32'h0,   0, 1, 0), 301);
        run_row(mk(0, 32'h0,   0, 0,       0, 0, 0,       0, 1, 32'h0,   0, 32'h0,    32'h0,   0, 1, 0), 302);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
